// File: rtl/fcvt_arb.sv
// fcvt_arb: two-requester round-robin arbiter feeding one registered
// float32 -> int32 converter (truncation toward zero).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in0_valid/in1_valid       requester holds a float operand
//   in0_a/in1_a [31:0]        IEEE-754 single-precision operands
//   in0_ready/in1_ready       operand accepted this cycle
//   out_valid, out_ready      result register handshake
//   out_d [31:0], out_id      signed integer result and requester index
//   out_p_lost/denorm/invalid per-result flags
//   flags_clr                 clears sticky flags and done_cnt
//   sticky_*                  flags OR-accumulated over output handshakes
//   done_cnt [15:0]           completed output handshakes (wraps)
module fcvt_arb #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic        in1_valid,
  input  logic [31:0] in0_a,
  input  logic [31:0] in1_a,
  output logic        in0_ready,
  output logic        in1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_d,
  output logic        out_id,
  output logic        out_p_lost,
  output logic        out_denorm,
  output logic        out_invalid,
  input  logic        flags_clr,
  output logic        sticky_p_lost,
  output logic        sticky_denorm,
  output logic        sticky_invalid,
  output logic [15:0] done_cnt
);

  logic        prio_q, prio_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_d_q, out_d_d;
  logic        out_id_q, out_id_d;
  logic        out_pl_q, out_pl_d;
  logic        out_dn_q, out_dn_d;
  logic        out_inv_q, out_inv_d;
  logic        st_pl_q, st_pl_d;
  logic        st_dn_q, st_dn_d;
  logic        st_inv_q, st_inv_d;
  logic [15:0] cnt_q, cnt_d;

  logic        accept, any_vld, gnt_id, take, hs;
  logic [31:0] sel_a;

  // Arbitration and input handshake
  always_comb begin
    accept  = !out_valid_q || out_ready;
    any_vld = in0_valid || in1_valid;
    // Contention goes to the priority holder, otherwise whoever is valid.
    gnt_id  = (in0_valid && in1_valid) ? prio_q : !in0_valid;
    take    = !rst && accept && any_vld;
    in0_ready = take && !gnt_id;
    in1_ready = take && gnt_id;
    sel_a   = gnt_id ? in1_a : in0_a;
  end

  // Conversion of the granted operand
  logic [7:0]  cv_e;
  logic [22:0] cv_f;
  logic [54:0] cv_wide;
  logic [31:0] cv_mag;
  logic [31:0] cv_d;
  logic        cv_pl, cv_dn, cv_inv;

  always_comb begin
    cv_e    = sel_a[30:23];
    cv_f    = sel_a[22:0];
    // Hidden-1 mantissa shifted by the unbiased exponent: bits [54:23] are
    // the integer part, [22:0] the discarded fraction.
    cv_wide = 55'({1'b1, cv_f}) << (cv_e - 8'd127);
    cv_mag  = cv_wide[54:23];
    cv_dn   = (cv_e == 8'd0) && (cv_f != 23'd0);
    cv_d    = '0;
    cv_pl   = 1'b0;
    cv_inv  = 1'b0;
    if (cv_e == 8'd0) begin
      cv_pl = cv_dn;
    end else if (cv_e <= 8'd126) begin
      cv_pl = 1'b1;
    end else if (cv_e <= 8'd157) begin
      cv_d  = sel_a[31] ? -cv_mag : cv_mag;
      cv_pl = |cv_wide[22:0];
    end else begin
      // -2^31 is exactly representable; everything else overflows.
      cv_d   = 32'h8000_0000;
      cv_inv = (sel_a != 32'hCF00_0000);
    end
  end

  // Next-state logic
  always_comb begin
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    out_id_d    = out_id_q;
    out_pl_d    = out_pl_q;
    out_dn_d    = out_dn_q;
    out_inv_d   = out_inv_q;

    if (accept) begin
      out_valid_d = any_vld;
      if (any_vld) begin
        out_d_d   = cv_d;
        out_id_d  = gnt_id;
        out_pl_d  = cv_pl;
        out_dn_d  = cv_dn;
        out_inv_d = cv_inv;
        prio_d    = !gnt_id;
      end
    end

    // Clear and a coinciding handshake combine: cleared base plus this result.
    hs       = out_valid_q && out_ready;
    st_pl_d  = (flags_clr ? 1'b0 : st_pl_q)  | (hs & out_pl_q);
    st_dn_d  = (flags_clr ? 1'b0 : st_dn_q)  | (hs & out_dn_q);
    st_inv_d = (flags_clr ? 1'b0 : st_inv_q) | (hs & out_inv_q);
    cnt_d    = (flags_clr ? 16'd0 : cnt_q) + {15'd0, hs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= RR_INIT[0];
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      out_id_q    <= 1'b0;
      out_pl_q    <= 1'b0;
      out_dn_q    <= 1'b0;
      out_inv_q   <= 1'b0;
      st_pl_q     <= 1'b0;
      st_dn_q     <= 1'b0;
      st_inv_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
      out_id_q    <= out_id_d;
      out_pl_q    <= out_pl_d;
      out_dn_q    <= out_dn_d;
      out_inv_q   <= out_inv_d;
      st_pl_q     <= st_pl_d;
      st_dn_q     <= st_dn_d;
      st_inv_q    <= st_inv_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_d          = out_d_q;
  assign out_id         = out_id_q;
  assign out_p_lost     = out_pl_q;
  assign out_denorm     = out_dn_q;
  assign out_invalid    = out_inv_q;
  assign sticky_p_lost  = st_pl_q;
  assign sticky_denorm  = st_dn_q;
  assign sticky_invalid = st_inv_q;
  assign done_cnt       = cnt_q;

endmodule

// File: tb/tb_fcvt_arb.sv
module tb_fcvt_arb;

  localparam int unsigned RRI = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_valid = 1'b0, in1_valid = 1'b0;
  logic [31:0] in0_a = '0, in1_a = '0;
  logic        in0_ready, in1_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_d;
  logic        out_id, out_p_lost, out_denorm, out_invalid;
  logic        flags_clr = 1'b0;
  logic        sticky_p_lost, sticky_denorm, sticky_invalid;
  logic [15:0] done_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fcvt_arb #(.RR_INIT(RRI)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in1_valid(in1_valid),
    .in0_a(in0_a), .in1_a(in1_a),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_id(out_id),
    .out_p_lost(out_p_lost), .out_denorm(out_denorm), .out_invalid(out_invalid),
    .flags_clr(flags_clr),
    .sticky_p_lost(sticky_p_lost), .sticky_denorm(sticky_denorm),
    .sticky_invalid(sticky_invalid), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference conversion from the numeric definition: value = mant * 2^(e-150).
  function automatic void ref_conv(input logic [31:0] a, output logic [31:0] d,
                                   output logic pl, output logic dn, output logic inv);
    int unsigned       e;
    longint unsigned   m, dv, mag;
    logic [31:0]       m32;
    e   = int'(a[30:23]);
    m   = 64'h80_0000 + longint'(a[22:0]);
    dn  = (e == 0) && (a[22:0] != 0);
    d   = 32'd0;
    pl  = 1'b0;
    inv = 1'b0;
    if (e == 0) begin
      pl = dn;
    end else if (e < 127) begin
      pl = 1'b1;
    end else if (e <= 157) begin
      if (e >= 150) begin
        mag = m * (64'd1 << (e - 150));
      end else begin
        dv  = 64'd1 << (150 - e);
        mag = m / dv;
        pl  = (m % dv) != 0;
      end
      m32 = mag[31:0];
      d   = a[31] ? (32'd0 - m32) : m32;
    end else begin
      d   = 32'h8000_0000;
      inv = (a != 32'hCF00_0000);
    end
  endfunction

  // Reference state: what the output registers must hold.
  logic        armed = 1'b0;
  logic        m_valid, m_id, m_pl, m_dn, m_inv, m_prio;
  logic [31:0] m_d;
  logic        m_spl, m_sdn, m_sinv;
  int unsigned m_cnt;

  always begin
    logic acc, have, g, e0, e1, hs;
    logic [31:0] cd;
    logic cpl, cdn, cinv;
    @(negedge clk);
    #1;
    acc  = !m_valid || out_ready;
    have = in0_valid || in1_valid;
    if (in0_valid && in1_valid) g = m_prio;
    else                        g = in1_valid;
    e0 = !rst && acc && have && (g == 1'b0);
    e1 = !rst && acc && have && (g == 1'b1);
    if (armed) begin
      chk("in0_ready", 32'(in0_ready), 32'(e0));
      chk("in1_ready", 32'(in1_ready), 32'(e1));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_d", out_d, m_d);
      chk("out_id", 32'(out_id), 32'(m_id));
      chk("out_p_lost", 32'(out_p_lost), 32'(m_pl));
      chk("out_denorm", 32'(out_denorm), 32'(m_dn));
      chk("out_invalid", 32'(out_invalid), 32'(m_inv));
      chk("sticky_p_lost", 32'(sticky_p_lost), 32'(m_spl));
      chk("sticky_denorm", 32'(sticky_denorm), 32'(m_sdn));
      chk("sticky_invalid", 32'(sticky_invalid), 32'(m_sinv));
      chk("done_cnt", 32'(done_cnt), m_cnt);
    end
    if (rst) begin
      armed = 1'b1;
      m_valid = 0; m_id = 0; m_pl = 0; m_dn = 0; m_inv = 0; m_d = 0;
      m_spl = 0; m_sdn = 0; m_sinv = 0; m_cnt = 0;
      m_prio = RRI[0];
    end else if (armed) begin
      hs = m_valid && out_ready;
      if (flags_clr) begin
        m_spl = 0; m_sdn = 0; m_sinv = 0; m_cnt = 0;
      end
      if (hs) begin
        m_spl  = m_spl | m_pl;
        m_sdn  = m_sdn | m_dn;
        m_sinv = m_sinv | m_inv;
        m_cnt  = (m_cnt + 1) % 65536;
      end
      if (acc) begin
        m_valid = have;
        if (have) begin
          ref_conv(g ? in1_a : in0_a, cd, cpl, cdn, cinv);
          m_d = cd; m_pl = cpl; m_dn = cdn; m_inv = cinv;
          m_id = g;
          m_prio = !g;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    tick;
    rst = 1; in0_valid = 0; in1_valid = 0; flags_clr = 0; out_ready = 0;
    tick;
    rst = 0;
  endtask

  function automatic logic [31:0] rand_operand;
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: rand_operand = r;
      1, 2: begin
        e = 8'($urandom_range(120, 160));
        rand_operand = {r[31], e, r[22:0]};
      end
      3: rand_operand = {r[31], 8'd0, (r[1] ? r[22:0] : 23'd0)};
      4: rand_operand = {r[31], 8'hFF, (r[1] ? r[22:0] : 23'd0)};
      default: begin
        case (r[2:0])
          0: rand_operand = 32'hCF00_0000;
          1: rand_operand = 32'h4F00_0000;
          2: rand_operand = 32'h4EFF_FFFF;
          3: rand_operand = 32'hCEFF_FFFF;
          4: rand_operand = 32'h3F80_0000;
          5: rand_operand = 32'hBF80_0001;
          6: rand_operand = 32'h3F00_0000;
          default: rand_operand = 32'h0000_0001;
        endcase
      end
    endcase
  endfunction

  // Hand-computed conversion results that pin the reference function.
  logic [31:0] pin_a  [10] = '{32'h40490FDB, 32'hC2C80000, 32'h4F000000, 32'hCF000000,
                               32'h00000001, 32'h3F000000, 32'h3F800000, 32'h7FC00000,
                               32'h4EFFFFFF, 32'hBF800001};
  logic [31:0] pin_d  [10] = '{32'h3, 32'hFFFFFF9C, 32'h80000000, 32'h80000000,
                               32'h0, 32'h0, 32'h1, 32'h80000000,
                               32'h7FFFFF80, 32'hFFFFFFFF};
  logic [3:0]  pin_f  [10] = '{4'b100, 4'b000, 4'b001, 4'b000, 4'b110, 4'b100, 4'b000,
                               4'b001, 4'b000, 4'b100}; // {p_lost, denorm, invalid}

  initial begin
    logic [31:0] rd;
    logic rpl, rdn, rinv;

    for (int i = 0; i < 10; i++) begin
      ref_conv(pin_a[i], rd, rpl, rdn, rinv);
      chk("pin_d", rd, pin_d[i]);
      chk("pin_flags", {29'd0, rpl, rdn, rinv}, {28'd0, pin_f[i]});
    end

    repeat (2) tick;
    rst = 0;

    // Single operand, one-cycle latency, count after handshake
    in0_valid = 1; in0_a = 32'h40490FDB; out_ready = 1;
    tick; in0_valid = 0; #2;
    chk("pi_valid", 32'(out_valid), 32'd1);
    chk("pi_d", out_d, 32'd3);
    chk("pi_pl", 32'(out_p_lost), 32'd1);
    chk("pi_id", 32'(out_id), 32'd0);
    tick; #2;
    chk("pi_cnt", 32'(done_cnt), 32'd1);

    // Contention alternates starting from RR_INIT
    do_reset;
    in0_valid = 1; in0_a = 32'h3F800000; in1_valid = 1; in1_a = 32'hC2C80000; out_ready = 1;
    #2;
    chk("rr_rdy0", 32'(in0_ready), 32'd1);
    chk("rr_rdy1", 32'(in1_ready), 32'd0);
    tick; #2;
    chk("rr_d0", out_d, 32'd1);
    chk("rr_id0", 32'(out_id), 32'd0);
    chk("rr_rdy1b", 32'(in1_ready), 32'd1);
    tick; in0_valid = 0; in1_valid = 0; #2;
    chk("rr_d1", out_d, 32'hFFFFFF9C);
    chk("rr_id1", 32'(out_id), 32'd1);

    // Backpressure holds the result and blocks both requesters
    do_reset;
    in0_valid = 1; in0_a = 32'h3F800000;
    tick; in0_valid = 0; in1_valid = 1; in1_a = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_d", out_d, 32'd1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_rdy1", 32'(in1_ready), 32'd0);
      chk("bp_cnt", 32'(done_cnt), 32'd0);
      tick;
    end
    out_ready = 1; #2;
    chk("bp_release", 32'(in1_ready), 32'd1);
    tick; in1_valid = 0; #2;
    chk("bp_d2", out_d, 32'd2);
    chk("bp_id2", 32'(out_id), 32'd1);
    chk("bp_cnt2", 32'(done_cnt), 32'd1);

    // Overflow boundary and NaN
    do_reset;
    out_ready = 1; in0_valid = 1; in0_a = 32'h4F000000;
    tick; in0_a = 32'hCF000000; #2;
    chk("ov_d0", out_d, 32'h80000000);
    chk("ov_inv0", 32'(out_invalid), 32'd1);
    tick; in0_a = 32'h7FC00000; #2;
    chk("ov_d1", out_d, 32'h80000000);
    chk("ov_inv1", 32'(out_invalid), 32'd0);
    tick; in0_valid = 0; #2;
    chk("ov_inv2", 32'(out_invalid), 32'd1);
    tick; #2;
    chk("ov_sticky", 32'(sticky_invalid), 32'd1);
    chk("ov_cnt", 32'(done_cnt), 32'd3);

    // Denormal, then clear coinciding with a handshake
    do_reset;
    out_ready = 1; in0_valid = 1; in0_a = 32'h00000001;
    tick; in0_a = 32'h3F000000; #2;
    chk("dn_d", out_d, 32'd0);
    chk("dn_dn", 32'(out_denorm), 32'd1);
    chk("dn_pl", 32'(out_p_lost), 32'd1);
    tick; in0_valid = 0; flags_clr = 1;
    tick; flags_clr = 0; #2;
    chk("clr_spl", 32'(sticky_p_lost), 32'd1);
    chk("clr_sdn", 32'(sticky_denorm), 32'd0);
    chk("clr_cnt", 32'(done_cnt), 32'd1);

    // Reset discards a held result and restores priority
    do_reset;
    in0_valid = 1; in0_a = 32'h40400000;
    tick; in0_valid = 0; rst = 1; #2;
    chk("rs_pre", 32'(out_valid), 32'd1);
    chk("rs_rdy", 32'(in1_ready | in0_ready), 32'd0);
    tick; rst = 0; in0_valid = 1; in1_valid = 1; #2;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_cnt", 32'(done_cnt), 32'd0);
    chk("rs_g0", 32'(in0_ready), 32'd1);
    chk("rs_g1", 32'(in1_ready), 32'd0);

    // Randomized traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      tick;
      rst       = ($urandom_range(0, 99) == 0);
      flags_clr = ($urandom_range(0, 29) == 0);
      in0_valid = ($urandom_range(0, 9) < 6);
      in1_valid = ($urandom_range(0, 9) < 6);
      in0_a     = rand_operand();
      in1_a     = rand_operand();
      out_ready = ($urandom_range(0, 9) < 7);
    end
    tick; rst = 0; in0_valid = 0; in1_valid = 0; flags_clr = 0; out_ready = 1;
    repeat (2) tick;
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fcvt_arb.md
FCVT_ARB -- requirements
Module: fcvt_arb

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in0_valid/in1_valid  input  1  requester holds a float operand.
REQ-005 SHALL have ports in0_a/in1_a  input  32  IEEE-754 single-precision operand.
REQ-006 SHALL have ports in0_ready/in1_ready  output  1  operand accepted this cycle.
REQ-007 SHALL have port out_valid  output  1  result register holds a result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-009 SHALL have ports out_d  output  32  signed integer result; out_id  output  1  requester index.
REQ-010 SHALL have ports out_p_lost, out_denorm, out_invalid  output  1 each  per-result flags.
REQ-011 SHALL have port flags_clr  input  1  clears sticky flags and counter.
REQ-012 SHALL have ports sticky_p_lost, sticky_denorm, sticky_invalid  output  1 each  accumulated flags.
REQ-013 SHALL have port done_cnt  output  16  completed output handshakes since reset or clear.

Function
REQ-014 SHALL define accept = !out_valid || out_ready; it SHALL accept at most one operand per cycle.
REQ-015 Arbitration: one valid requester is granted; both valid grants the priority holder; none valid grants nobody.
REQ-016 inX_ready SHALL be accept && grant==X; never both high; a non-granted requester SHALL see ready low.
REQ-017 After each accepted operand, priority SHALL pass to the other requester (strict alternation under contention).
REQ-018 On accept with a grant, out_valid SHALL be 1 next cycle with converted result, flags and out_id registered; latency exactly 1 cycle.
REQ-019 On accept with no grant, out_valid SHALL go to 0 next cycle; otherwise (out_valid && !out_ready) all out_* SHALL hold stable.
REQ-020 Back-to-back: with out_ready held 1 and continuous valid, one result per cycle.
REQ-021 Conversion: e=a[30:23], f=a[22:0], truncation toward zero; out_denorm = (e==0 && f!=0).
REQ-022 e==0: out_d=0, out_p_lost=out_denorm, out_invalid=0.
REQ-023 1<=e<=126: out_d=0, out_p_lost=1, out_invalid=0.
REQ-024 127<=e<=157: out_d = two's-complement signed integer magnitude floor(|x|); out_p_lost=1 iff any discarded fraction bit is 1; out_invalid=0.
REQ-025 e>=158 (incl. Inf/NaN): out_d=0x80000000, out_invalid=1, out_p_lost=0; exception: a==0xCF000000 yields 0x80000000, out_invalid=0, out_p_lost=0.
REQ-026 On output handshake (out_valid && out_ready) sticky flags SHALL OR in the result flags and done_cnt SHALL increment, wrapping 0xFFFF->0x0000.
REQ-027 flags_clr SHALL zero sticky flags and done_cnt next cycle; if a handshake coincides, the result is the cleared value plus that handshake's contribution (sticky = its flags, done_cnt=1).

Reset
REQ-028 rst SHALL force next cycle: out_valid=0, out_d=0, out_id=0, out_* flags=0, sticky flags=0, done_cnt=0, priority=RR_INIT.
REQ-029 rst SHALL dominate all inputs; inX_ready SHALL be 0 while rst=1; a held result SHALL be discarded without counting.

Verification
REQ-030 in0_valid, a=0x40490FDB, out_ready=1 -> next cycle out_valid=1, out_d=3, out_p_lost=1, out_id=0, done_cnt=1.
REQ-031 RR_INIT=0, in0 a=0x3F800000 and in1 a=0xC2C80000 both valid -> results out_d=1 (id 0) then 0xFFFFFF9C (id 1) on consecutive cycles.
REQ-032 out_valid with out_ready=0 for 3 cycles, in1 valid -> out_* stable, in0_ready=in1_ready=0, done_cnt unchanged; release -> in1 accepted same cycle.
REQ-033 Operands 0x4F000000, 0xCF000000, 0x7FC00000 -> 0x80000000/invalid=1, 0x80000000/invalid=0, 0x80000000/invalid=1; sticky_invalid=1.
REQ-034 a=0x00000001 -> out_d=0, denorm=1, p_lost=1; then flags_clr coincident with handshake of 0x3F000000 -> sticky_p_lost=1, sticky_denorm=0, done_cnt=1.
REQ-035 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, done_cnt=0, first post-reset grant follows RR_INIT.
